// File: rtl/cam_pkg.sv
// Shared definitions for the CAM write path: CAM mode encodings, BF16 field layout,
// address split and the loader FSM state type.
package cam_pkg;

    localparam logic [2:0] CAM_IDLE  = 3'b000;
    localparam logic [2:0] CAM_STORE = 3'b001;

    localparam int unsigned BF16_SIGN_BIT = 15;
    localparam int unsigned BF16_EXP_MSB  = 14;
    localparam int unsigned BF16_EXP_LSB  = 7;
    localparam int unsigned BF16_MAN_MSB  = 6;
    localparam logic [7:0]  EXP_SPECIAL   = 8'hFF;

    // cmp_addr = {row, col}
    localparam int unsigned CAM_ADDR_W = 10;
    localparam int unsigned CAM_ROW_W  = 5;
    localparam int unsigned CAM_COL_W  = 5;

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StWrite,
        StCommit,
        StDone
    } loader_state_e;

    function automatic logic is_exp_special(input logic [15:0] word);
        return word[BF16_EXP_MSB:BF16_EXP_LSB] == EXP_SPECIAL;
    endfunction

endpackage

// File: rtl/cam_store_loader.sv
// Write sequencer for CAM_Top: takes BF16 words over valid/ready, holds each in STORE mode
// for WR_CYCLES cycles at consecutive addresses, then commits the burst with update_signal.
module cam_store_loader
    import cam_pkg::*;
#(
    parameter int unsigned WR_CYCLES = 2,
    parameter int unsigned ADDR_W    = CAM_ADDR_W,
    parameter int unsigned CNT_W     = 11
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    output logic              in_ready,
    output logic [15:0]       data_in,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic [2:0]        state_ctrl,
    output logic              update_signal,
    output logic              busy,
    output logic              done,
    output logic              exp_special
);

    localparam logic [3:0] HOLD_INIT = 4'(WR_CYCLES - 1);

    loader_state_e     state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              exp_q, exp_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        data_d  = data_q;
        exp_d   = exp_q;
        // abort outranks every other input, but only outside IDLE
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (count != '0) begin
                            addr_d  = base_addr;
                            rem_d   = count;
                            exp_d   = 1'b0;
                            state_d = StWaitData;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StWaitData: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        hold_d  = HOLD_INIT;
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    if (is_exp_special(data_q)) begin
                        exp_d = 1'b1;
                    end
                    if (hold_q == 4'd0) begin
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                        state_d = (rem_q == CNT_W'(1)) ? StCommit : StWaitData;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                StCommit: state_d = StDone;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
        end
    end

    // Control outputs are pure decodes of the state register: no path from in_valid.
    assign in_ready      = (state_q == StWaitData);
    assign state_ctrl    = (state_q == StWrite) ? CAM_STORE : CAM_IDLE;
    assign update_signal = (state_q == StCommit);
    assign done          = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign data_in       = data_q;
    assign cmp_addr      = addr_q;
    assign exp_special   = exp_q;

endmodule

// File: tb/tb_cam_store_loader.sv
// Directed bench for cam_store_loader: per-cycle STORE log checked against hand-built
// address/data sequences, plus pulse counts and reset/abort behaviour.
module tb_cam_store_loader;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] data_in;
    logic [9:0]  cmp_addr;
    logic [2:0]  state_ctrl;
    logic        update_signal;
    logic        busy;
    logic        done;
    logic        exp_special;

    cam_store_loader #(
        .WR_CYCLES (2),
        .ADDR_W    (10),
        .CNT_W     (11)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .count         (count),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .cmp_addr      (cmp_addr),
        .state_ctrl    (state_ctrl),
        .update_signal (update_signal),
        .busy          (busy),
        .done          (done),
        .exp_special   (exp_special)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [15:0] feed_mem [8];
    int          feed_idx = 0;
    logic [25:0] store_log [$];
    logic [25:0] exp_log [$];
    int          upd_cnt = 0;
    int          done_cnt = 0;
    int          log_base, upd_base, done_base;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Logs the cycle being left, then advances one clock; sampling is at negedge.
    task automatic tick();
        logic hs;
        if (state_ctrl == 3'b001) store_log.push_back({cmp_addr, data_in});
        if (update_signal) upd_cnt++;
        if (done) done_cnt++;
        hs = in_valid && in_ready && rst;
        @(posedge CLK);
        @(negedge CLK);
        if (hs && feed_idx < 7) begin
            feed_idx++;
            in_data = feed_mem[feed_idx];
        end
    endtask

    task automatic load_feed(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        feed_mem[0] = w0;
        feed_mem[1] = w1;
        feed_mem[2] = w2;
        feed_mem[3] = w3;
        for (int i = 4; i < 8; i++) feed_mem[i] = 16'hDEAD;
        feed_idx = 0;
        in_data  = w0;
    endtask

    task automatic mark();
        log_base  = store_log.size();
        upd_base  = upd_cnt;
        done_base = done_cnt;
        exp_log.delete();
    endtask

    task automatic add_exp(input logic [9:0] addr, input logic [15:0] data);
        exp_log.push_back({addr, data});
        exp_log.push_back({addr, data});
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_log_len"}, store_log.size() - log_base, exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            if (log_base + i < store_log.size())
                check_eq($sformatf("%s_log%0d", tag, i), {6'd0, store_log[log_base + i]},
                         {6'd0, exp_log[i]});
        end
    endtask

    task automatic begin_burst(input logic [9:0] b, input logic [10:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) tick();
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_fed(input string tag, input int target);
        for (int i = 0; i < 30 && feed_idx < target; i++) tick();
        check_eq({tag, "_fed"}, feed_idx, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_data_in"}, data_in, 16'h0000);
        check_eq({tag, "_cmp_addr"}, cmp_addr, 10'd0);
        check_eq({tag, "_state_ctrl"}, state_ctrl, 3'b000);
        check_eq({tag, "_update"}, update_signal, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_exp_special"}, exp_special, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] sc_pat, rdy_pat, upd_pat, done_pat, busy_pat;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        base_addr = '0;
        count     = '0;
        load_feed(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(negedge CLK);
        check_reset_outputs("rst_in");
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_out");

        // Burst of 3 at 32: bit i of each pattern is cycle i+1 after the start edge
        sc_pat   = 12'b000110110110;
        rdy_pat  = 12'b000001001001;
        upd_pat  = 12'b001000000000;
        done_pat = 12'b010000000000;
        busy_pat = 12'b011111111111;
        mark();
        load_feed(16'hE26F, 16'h3F80, 16'h0000, 16'h0000);
        in_valid = 1'b1;
        begin_burst(10'b00001_00000, 11'd3);
        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("t1_state_ctrl_c%0d", i + 1), state_ctrl, {2'b00, sc_pat[i]});
            check_eq($sformatf("t1_in_ready_c%0d", i + 1), in_ready, rdy_pat[i]);
            check_eq($sformatf("t1_update_c%0d", i + 1), update_signal, upd_pat[i]);
            check_eq($sformatf("t1_done_c%0d", i + 1), done, done_pat[i]);
            check_eq($sformatf("t1_busy_c%0d", i + 1), busy, busy_pat[i]);
            tick();
        end
        in_valid = 1'b0;
        add_exp(10'd32, 16'hE26F);
        add_exp(10'd33, 16'h3F80);
        add_exp(10'd34, 16'h0000);
        check_log("t1");
        check_eq("t1_upd_count", upd_cnt - upd_base, 1);
        check_eq("t1_done_count", done_cnt - done_base, 1);
        check_eq("t1_exp_special", exp_special, 1'b0);
        check_eq("t1_cmp_addr_end", cmp_addr, 10'd35);

        // Address wrap 1023 -> 0
        mark();
        load_feed(16'h1234, 16'h5678, 16'h0, 16'h0);
        in_valid = 1'b1;
        begin_burst(10'd1023, 11'd2);
        run_until_idle("t2", 40);
        in_valid = 1'b0;
        add_exp(10'd1023, 16'h1234);
        add_exp(10'd0, 16'h5678);
        check_log("t2");
        check_eq("t2_cmp_addr_end", cmp_addr, 10'd1);
        check_eq("t2_upd_count", upd_cnt - upd_base, 1);
        check_eq("t2_done_count", done_cnt - done_base, 1);

        // Zero-length burst
        mark();
        begin_burst(10'd500, 11'd0);
        check_eq("t3_done_c1", done, 1'b1);
        check_eq("t3_busy_c1", busy, 1'b1);
        check_eq("t3_in_ready_c1", in_ready, 1'b0);
        check_eq("t3_state_ctrl_c1", state_ctrl, 3'b000);
        tick();
        check_eq("t3_done_c2", done, 1'b0);
        check_eq("t3_busy_c2", busy, 1'b0);
        check_log("t3");
        check_eq("t3_upd_count", upd_cnt - upd_base, 0);
        check_eq("t3_cmp_addr_kept", cmp_addr, 10'd1);

        // Burst of 4 with a 5-cycle valid gap before word 3 (an Inf word)
        mark();
        load_feed(16'h4000, 16'h4040, 16'h7F80, 16'h3C00);
        in_valid = 1'b1;
        begin_burst(10'd100, 11'd4);
        wait_fed("t4_w2", 2);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !in_ready; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t4_gap_state_ctrl_%0d", i), state_ctrl, 3'b000);
            check_eq($sformatf("t4_gap_in_ready_%0d", i), in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b1;
        run_until_idle("t4", 60);
        in_valid = 1'b0;
        add_exp(10'd100, 16'h4000);
        add_exp(10'd101, 16'h4040);
        add_exp(10'd102, 16'h7F80);
        add_exp(10'd103, 16'h3C00);
        check_log("t4");
        check_eq("t4_exp_special", exp_special, 1'b1);
        check_eq("t4_upd_count", upd_cnt - upd_base, 1);
        check_eq("t4_done_count", done_cnt - done_base, 1);

        // Abort in the second WRITE cycle of word 2 of 4, then a fresh burst
        mark();
        load_feed(16'h1111, 16'h2222, 16'h5555, 16'h6666);
        in_valid = 1'b1;
        begin_burst(10'd200, 11'd4);
        wait_fed("t5_w2", 2);
        check_eq("t5_exp_cleared", exp_special, 1'b0);
        tick();
        check_eq("t5_write_c2", state_ctrl, 3'b001);
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("t5_abort_busy", busy, 1'b0);
        check_eq("t5_abort_state_ctrl", state_ctrl, 3'b000);
        check_eq("t5_abort_in_ready", in_ready, 1'b0);
        repeat (3) tick();
        add_exp(10'd200, 16'h1111);
        add_exp(10'd201, 16'h2222);
        check_log("t5");
        check_eq("t5_upd_count", upd_cnt - upd_base, 0);
        check_eq("t5_done_count", done_cnt - done_base, 0);
        mark();
        load_feed(16'h3333, 16'h0, 16'h0, 16'h0);
        in_valid = 1'b1;
        begin_burst(10'd300, 11'd1);
        check_eq("t5_restart_busy", busy, 1'b1);
        run_until_idle("t5_restart", 30);
        in_valid = 1'b0;
        add_exp(10'd300, 16'h3333);
        check_log("t5_restart");
        check_eq("t5_restart_upd", upd_cnt - upd_base, 1);
        check_eq("t5_restart_done", done_cnt - done_base, 1);
        check_eq("t5_restart_addr", cmp_addr, 10'd301);

        // Asynchronous reset mid-WRITE
        load_feed(16'h4444, 16'h7F85, 16'h0, 16'h0);
        in_valid = 1'b1;
        begin_burst(10'd400, 11'd2);
        wait_fed("t6_w1", 1);
        check_eq("t6_mid_write", state_ctrl, 3'b001);
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        mark();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t6_held_in_ready_%0d", i), in_ready, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("t6_after_busy_%0d", i), busy, 1'b0);
            check_eq($sformatf("t6_after_in_ready_%0d", i), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check_log("t6");
        check_eq("t6_upd_count", upd_cnt - upd_base, 0);
        check_eq("t6_done_count", done_cnt - done_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
